// File: rtl/dds_tone_gen.sv
// DDS tone source: phase accumulator -> quarter-wave sine LUT -> gain -> AXI-Stream out.
// Define DDS_PHASE_DITHER_EN to add LFSR phase dither ahead of the LUT index.
module dds_tone_gen #(
  parameter int BITS    = 16,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [BITS-1:0]    amplitude,
  output logic [BITS-1:0]    m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);

  localparam int LUT_N = 2 ** LUT_AW;
  localparam logic [BITS:0] UNITY = {2'b01, {(BITS-1){1'b0}}};

  // Half-step offset makes entry k the mirror of entry LUT_N-1-k.
  function automatic int lut_entry(int k);
    real ang;
    ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    return $rtoi(real'(2 ** (BITS - 1) - 1) * $sin(ang) + 0.5);
  endfunction

  logic [BITS-2:0] lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam int VAL = lut_entry(k);
    assign lut[k] = (BITS-1)'(VAL);
  end

  logic                     adv;
  logic [PHASE_W-1:0]       acc;
  logic [LUT_AW+1:0]        phase_top;
  logic [LUT_AW+1:0]        ph0;
  logic                     v0, v1, v2;
  logic signed [BITS-1:0]   sine;
  logic signed [BITS-1:0]   scaled;
  logic [1:0]               q;
  logic [LUT_AW-1:0]        a;
  logic [LUT_AW-1:0]        idx;
  logic [BITS-2:0]          mag;
  logic [BITS:0]            g;
  logic signed [2*BITS:0]   prod;

  assign adv = ~m_axis_tvalid | m_axis_tready;

`ifdef DDS_PHASE_DITHER_EN
  localparam int DW = (PHASE_W - 2 - LUT_AW > 16) ? 16 : PHASE_W - 2 - LUT_AW;
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (adv && enable) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign phase_top = (LUT_AW+2)'((acc + PHASE_W'(lfsr[DW-1:0])) >> (PHASE_W - 2 - LUT_AW));
`else
  assign phase_top = acc[PHASE_W-1 -: LUT_AW+2];
`endif

  always_comb begin
    q    = ph0[LUT_AW+1 -: 2];
    a    = ph0[LUT_AW-1:0];
    idx  = q[0] ? ~a : a;
    mag  = lut[idx];
    g    = ({1'b0, amplitude} > UNITY) ? UNITY : {1'b0, amplitude};
    prod = sine * $signed(g);
  end

  // tdata only loads on a valid sample so it holds its last value through gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      ph0           <= '0;
      v0            <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      sine          <= '0;
      scaled        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (adv) begin
      v0 <= enable;
      if (enable) begin
        ph0 <= phase_top;
        acc <= acc + phase_inc;
      end
      v1            <= v0;
      sine          <= q[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      v2            <= v1;
      scaled        <= BITS'(prod >>> (BITS - 1));
      m_axis_tvalid <= v2;
      if (v2) begin
        m_axis_tdata <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_dds_tone_gen.sv
// Self-checking bench for dds_tone_gen: directed scenarios plus randomized stall/enable traffic.
module tb_dds_tone_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] phase_inc;
  logic [15:0] amplitude;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  int vectors = 0;
  int miscompares = 0;
  longint unsigned nacc = 0;

  dds_tone_gen #(.BITS(16), .PHASE_W(32), .LUT_AW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .phase_inc     (phase_inc),
    .amplitude     (amplitude),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] sx(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Reference: the n-th sample of a tone is defined by phase n*inc, quadrant symmetry and floor gain.
  function automatic logic signed [31:0] model(longint unsigned n, logic [31:0] inc, logic [15:0] amp);
    logic [31:0] ph;
    int q, a, k, mag, s, g;
    real prod;
    ph  = inc * 32'(n);
    q   = int'(ph[31:30]);
    a   = int'(ph[29:22]);
    k   = (q % 2 == 1) ? 255 - a : a;
    mag = $rtoi(32767.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / 256.0) + 0.5);
    s   = (q >= 2) ? -mag : mag;
    g   = (int'(amp) > 32768) ? 32768 : int'(amp);
    prod = real'(s) * real'(g);
    return 32'($rtoi($floor(prod / 32768.0)));
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every accepted handshake is scored against the next reference sample.
  task automatic tick();
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      check("stream", sx(m_axis_tdata), model(nacc, phase_inc, amplitude));
      nacc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 0);
    check("rst_tdata", sx(m_axis_tdata), 0);
    rst = 1'b0;
    nacc = 0;
  endtask

  task automatic run_quad(input logic [15:0] amp, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    do_reset();
    phase_inc = 32'h4000_0000;
    amplitude = amp;
    m_axis_tready = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("first_valid_latency", {31'b0, m_axis_tvalid}, (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      check("quad_pattern", sx(m_axis_tdata), e[i % 4]);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    phase_inc = '0;
    amplitude = '0;
    m_axis_tready = 1'b0;
    #1;
    tick();

    // Reset and hold
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_axis_tready = i[0];
      tick();
      check("hold_tvalid", {31'b0, m_axis_tvalid}, 0);
      check("hold_tdata", sx(m_axis_tdata), 0);
    end

    // Unity quadrant tone, then stall, enable gap and mid-stream reset
    run_quad(16'd32768, 101, 32767, -101, -32767);

    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_tvalid", {31'b0, m_axis_tvalid}, 1);
      check("stall_tdata", sx(m_axis_tdata), model(nacc, phase_inc, amplitude));
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    enable = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) enable = 1'b1;
      tick();
      check("gap_tvalid", {31'b0, m_axis_tvalid}, (k >= 4 && k <= 7) ? 0 : 1);
      if (!m_axis_tvalid)
        check("gap_tdata_hold", sx(m_axis_tdata), model(nacc - 1, phase_inc, amplitude));
    end
    for (int i = 0; i < 8; i++) tick();

    rst = 1'b1;
    tick();
    check("midrst_tvalid", {31'b0, m_axis_tvalid}, 0);
    check("midrst_tdata", sx(m_axis_tdata), 0);
    rst = 1'b0;
    nacc = 0;
    for (int i = 1; i <= 4; i++) tick();
    check("midrst_restart_valid", {31'b0, m_axis_tvalid}, 1);
    check("midrst_restart_phase0", sx(m_axis_tdata), 101);
    for (int i = 0; i < 6; i++) tick();

    // Gain variants
    run_quad(16'd16384, 50, 16383, -51, -16384);
    run_quad(16'd0, 0, 0, 0, 0);
    run_quad(16'd65535, 101, 32767, -101, -32767);

    // 100-sample period tone against ideal sine
    begin
      int mx, mn;
      logic [31:0] ph;
      real ideal, err;
      mx = -100000;
      mn = 100000;
      do_reset();
      phase_inc = 32'd42949673;
      amplitude = 16'd32768;
      m_axis_tready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      for (int n = 0; n < 200; n++) begin
        ph = phase_inc * 32'(nacc);
        ideal = 32767.0 * $sin(2.0 * PI * (real'(ph[31:22]) + 0.5) / 1024.0);
        err = real'(sx(m_axis_tdata)) - ideal;
        check("sine_within_1lsb", {31'b0, m_axis_tvalid && err <= 1.0 && err >= -1.0}, 1);
        if (int'(sx(m_axis_tdata)) > mx) mx = int'(sx(m_axis_tdata));
        if (int'(sx(m_axis_tdata)) < mn) mn = int'(sx(m_axis_tdata));
        tick();
      end
      check("sine_max", mx, 32767);
      check("sine_min", mn, -32767);
    end

    // Randomized enable/backpressure traffic
    for (int b = 0; b < 4; b++) begin
      logic stalled;
      do_reset();
      phase_inc = $urandom;
      amplitude = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 80; i++) begin
        enable = ($urandom_range(0, 3) != 0);
        m_axis_tready = ($urandom_range(0, 3) != 0);
        stalled = m_axis_tvalid && !m_axis_tready;
        tick();
        if (stalled) begin
          check("rand_stall_tvalid", {31'b0, m_axis_tvalid}, 1);
          check("rand_stall_tdata", sx(m_axis_tdata), model(nacc, phase_inc, amplitude));
        end
      end
      enable = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_tone_gen.md
Name: dds_tone_gen

Overview:
- Direct digital synthesis tone source; drives the s_axis_tdata input of the downstream `dac` stage with signed two's-complement samples.
- Phase accumulator → quarter-wave sine LUT → amplitude scaling.
- Output is an AXI-Stream master; the stall-able pipeline honours tready backpressure.

Parameters:
- BITS, 16, output sample width; signed, full scale ±(2^(BITS-1)-1)
- PHASE_W, 32, phase accumulator width
- LUT_AW, 8, quarter-wave LUT address width (2^LUT_AW entries)

Ports:
- clk  in  1  single clock (430.08 MHz DAC sample clock)
- rst  in  1  synchronous, active-high reset
- enable  in  1  generate samples when high
- phase_inc  in  PHASE_W  frequency tuning word, unsigned; f_out = f_clk*phase_inc/2^PHASE_W
- amplitude  in  BITS  unsigned gain; 2^(BITS-1) = unity; larger values clamp to unity
- m_axis_tdata  out  BITS  signed sample to dac s_axis_tdata
- m_axis_tvalid  out  1  sample valid
- m_axis_tready  in  1  downstream accept

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - acc=0, all stage valids=0, m_axis_tvalid=0, m_axis_tdata=0.
  - Reset mid-stream discards in-flight samples; no handshake completes on the reset edge.
- Advance: adv = ~m_axis_tvalid | m_axis_tready. Every pipeline register, including acc, updates only when adv=1; otherwise all state holds.
  - tdata and tvalid are stable while tvalid=1 and tready=0.
- Stage 0 (accumulator):
  - On adv with enable=1: stage-0 phase register ← acc, v0←1, acc←acc+phase_inc (mod 2^PHASE_W).
  - On adv with enable=0: v0←0 and acc holds, so phase resumes seamlessly.
  - phase_inc is sampled at each update; a change takes effect on the next sample with no glitch logic.
- Stage 1 (LUT):
  - q = phase[PHASE_W-1:PHASE_W-2]; a = phase[PHASE_W-3 -: LUT_AW].
  - Index = a for q even, (2^LUT_AW-1)-a for q odd.
  - LUT[k] = round((2^(BITS-1)-1)*sin(pi/2*(k+0.5)/2^LUT_AW)); the half-step offset makes the mirror exact.
  - Registered sine = +LUT for q∈{0,1}, −LUT for q∈{2,3}.
- Stage 2 (gain):
  - g = min(amplitude, 2^(BITS-1)).
  - Product sine*g at full width (2*BITS+1 signed), arithmetic shift right by BITS-1, i.e. floor.
  - Result always fits in BITS bits; no saturation logic is needed.
- Stage 3 (output): m_axis_tdata/m_axis_tvalid registers.
- Latency: a sample whose phase is captured on adv edge N appears on m_axis_tdata after adv edge N+3. With tready=1, the first tvalid comes 3 cycles after enable is sampled high.
- Phase ordering:
  - First sample after reset uses phase 0.
  - No sample is dropped or duplicated across stalls or enable gaps.
  - tdata holds its last value while tvalid=0 (not reset to 0).
- Simultaneous events: enable falling while stalled has no effect until adv; rst overrides everything.

Optional Feature:
- Macro DDS_PHASE_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset, advancing on each acc update.
  - Its low (PHASE_W-2-LUT_AW) bits (capped at 16, LSB-aligned) are added to the truncated phase field before the LUT index is taken; carry into the index is allowed and wraps mod 2^PHASE_W.
  - Spreads truncation spurs.
- Undefined: plain truncation; no LFSR logic is present.

Test Plan:
1. Reset, then hold: tvalid=0, tdata=0. Reset asserted mid-stream: tvalid=0 on the next edge, and the first sample after release is phase 0.
2. phase_inc=32'h40000000, amplitude=32768, tready=1, enable=1 → repeating tdata 101, 32767, -101, -32767; first valid 3 cycles after enable.
3. Same as scenario 2 with amplitude=16384 → 50, 16383, -51, -16384. amplitude=0 → all 0. amplitude=65535 → same as unity.
4. phase_inc=42949673 (≈100 samples/cycle) → 100-sample period; every sample within ±1 LSB of 32767*sin(2πn/100 + half-step offset); max 32767, min -32767.
5. Scenario 2 with tready low for 5 cycles mid-run → tdata/tvalid frozen, and after release the sequence continues with no skipped or repeated sample.
6. Scenario 2 with enable low for 4 cycles → tvalid drops 3 cycles later for exactly 4 cycles; when samples resume, they continue the quadrant sequence from where it stopped.
